// File: rtl/fifo_rd_packer_pkg.sv
// ============================================================================
// Module      : fifo_rd_packer_pkg
// Description : Shared bounds and helper functions for the FIFO read packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_packer_pkg;

    localparam int c_PACK_MIN = 2;
    localparam int c_PACK_MAX = 8;

    // Width of a counter that must represent 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // One bit of a keep mask: lanes below the fill count carry data.
    function automatic logic keep_mask_bit(input int cnt, input int lane);
        return (lane < cnt);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rd_out_stage.sv
// ============================================================================
// Module      : rd_out_stage
// Description : Valid/ready holding register for one packed output beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_out_stage #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LANES-1:0]  i_keep,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [LANES-1:0]  o_keep,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [LANES-1:0]  r_keep;
    logic              r_last;

    // A load wins over a handshake so back-to-back beats keep valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// ============================================================================
// Module      : fifo_rd_packer
// Description : Pops words from an async FIFO read port and packs pack_Count
//               of them per output beat, with flush of partial beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int data_Size  = 8,
    parameter int pack_Count = 4
) (
    input  logic                          r_Clk,
    input  logic                          r_Rst,
    input  logic                          fifo_Empty,
    input  logic [data_Size-1:0]          read_Data,
    output logic                          r_Inc,
    input  logic                          flush_Req,
    output logic [data_Size*pack_Count-1:0] out_Data,
    output logic [pack_Count-1:0]         out_Keep,
    output logic                          out_Last,
    output logic                          out_Valid,
    input  logic                          out_Ready
);

    localparam int              c_CW   = cnt_width(pack_Count);
    localparam int              c_BW   = data_Size * pack_Count;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(pack_Count);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0]   r_acc_cnt;
    logic [c_CW-1:0]   w_cnt_next;
    logic [c_CW-1:0]   w_wr_lane;
    logic              r_flush_pend;
    logic              w_out_free;
    logic              w_move;
    logic              w_pop;
    logic              w_flush_set;
    logic [c_BW-1:0]   r_acc;
    logic [c_BW-1:0]   w_beat_data;
    logic [pack_Count-1:0] w_keep;

    assign w_out_free = ~out_Valid | out_Ready;
    assign w_move     = w_out_free &
                        ((r_acc_cnt == c_FULL) | (r_flush_pend & (r_acc_cnt != '0)));
    assign w_pop      = ~r_Rst & ~fifo_Empty & ~r_flush_pend &
                        ((r_acc_cnt < c_FULL) | w_move);
    assign r_Inc      = w_pop;

    // A pop that coincides with a move starts the next beat in lane 0.
    assign w_wr_lane  = w_move ? '0 : r_acc_cnt;

    always_comb begin
        w_cnt_next = r_acc_cnt;
        if (w_move && w_pop) begin
            w_cnt_next = c_ONE;
        end else if (w_move) begin
            w_cnt_next = '0;
        end else if (w_pop) begin
            w_cnt_next = r_acc_cnt + c_ONE;
        end
    end

    assign w_flush_set = flush_Req & ~r_flush_pend & (w_cnt_next != '0);

    always_ff @(posedge r_Clk) begin
        if (r_Rst) begin
            r_acc_cnt    <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_acc_cnt <= w_cnt_next;
            if (w_flush_set) begin
                r_flush_pend <= 1'b1;
            end else if (w_move) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge r_Clk) begin
        if (r_Rst) begin
            r_acc <= '0;
        end else begin
            for (int i = 0; i < pack_Count; i++) begin
                if (w_pop && (w_wr_lane == c_CW'(i))) begin
                    r_acc[i*data_Size +: data_Size] <= read_Data;
                end
            end
        end
    end

    // Lanes beyond the fill count are zeroed so stale words never leak out.
    generate
        for (genvar g = 0; g < pack_Count; g++) begin : g_lane
            assign w_keep[g] = keep_mask_bit(int'(r_acc_cnt), g);
            assign w_beat_data[g*data_Size +: data_Size] =
                w_keep[g] ? r_acc[g*data_Size +: data_Size] : '0;
        end
    endgenerate

    rd_out_stage #(
        .DATA_W (c_BW),
        .LANES  (pack_Count)
    ) u_out_stage (
        .clk     (r_Clk),
        .rst     (r_Rst),
        .i_load  (w_move),
        .i_data  (w_beat_data),
        .i_keep  (w_keep),
        .i_last  (r_flush_pend),
        .i_ready (out_Ready),
        .o_valid (out_Valid),
        .o_data  (out_Data),
        .o_keep  (out_Keep),
        .o_last  (out_Last)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// ============================================================================
// Module      : tb_fifo_rd_packer
// Description : Scoreboard bench for fifo_rd_packer (8-bit words, 4 lanes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_packer;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        r_Clk;
    logic        r_Rst;
    logic        fifo_Empty;
    logic [7:0]  read_Data;
    logic        r_Inc;
    logic        flush_Req;
    logic [31:0] out_Data;
    logic [3:0]  out_Keep;
    logic        out_Last;
    logic        out_Valid;
    logic        out_Ready;

    logic [7:0]  fifo_q[$];
    logic [7:0]  part[$];
    beat_t       sb[$];
    int          beat_cyc[$];

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  pops = 0;
    int  first_pop_cyc = -1;
    int  rdy_mode = 1;
    bit  gate_rand = 0;
    bit  rst_q = 1;
    bit  chk_noinc = 0;

    fifo_rd_packer #(
        .data_Size  (8),
        .pack_Count (4)
    ) dut (
        .r_Clk      (r_Clk),
        .r_Rst      (r_Rst),
        .fifo_Empty (fifo_Empty),
        .read_Data  (read_Data),
        .r_Inc      (r_Inc),
        .flush_Req  (flush_Req),
        .out_Data   (out_Data),
        .out_Keep   (out_Keep),
        .out_Last   (out_Last),
        .out_Valid  (out_Valid),
        .out_Ready  (out_Ready)
    );

    initial r_Clk = 1'b0;
    always #5 r_Clk = ~r_Clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_partial();
        beat_t b;
        b.d = '0;
        for (int i = 0; i < part.size(); i++) b.d[i*8 +: 8] = part[i];
        b.k = 4'((1 << part.size()) - 1);
        b.l = 1'b1;
        sb.push_back(b);
        part.delete();
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later.
    task automatic step(input bit fl);
        beat_t b;
        @(negedge r_Clk);
        r_Rst      = rst_q;
        flush_Req  = fl;
        fifo_Empty = (fifo_q.size() == 0) || (gate_rand && ($urandom_range(0, 1) == 0));
        read_Data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        case (rdy_mode)
            0:       out_Ready = 1'b0;
            1:       out_Ready = 1'b1;
            default: out_Ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (fifo_Empty) check_val("inc_while_empty", 64'(r_Inc), 64'd0);
        if (rst_q)      check_val("inc_during_reset", 64'(r_Inc), 64'd0);
        if (chk_noinc)  check_val("pop_during_flush", 64'(r_Inc), 64'd0);
        if (r_Inc && !fifo_Empty && fifo_q.size() != 0) begin
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            part.push_back(fifo_q.pop_front());
            pops++;
            if (part.size() == 4) begin
                b.d = {part[3], part[2], part[1], part[0]};
                b.k = 4'hF;
                b.l = 1'b0;
                sb.push_back(b);
                part.delete();
            end
        end
        if (fl && !rst_q && part.size() != 0) push_partial();
        if (out_Valid && out_Ready && !rst_q) begin
            beat_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check_val("unexpected_beat", 64'(out_Valid), 64'd0);
            end else begin
                b = sb.pop_front();
                check_val("beat_data", 64'(out_Data), 64'(b.d));
                check_val("beat_keep", 64'(out_Keep), 64'(b.k));
                check_val("beat_last", 64'(out_Last), 64'(b.l));
            end
        end
        cyc++;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((sb.size() != 0 || fifo_q.size() != 0) && n < max_cyc) begin
            step(1'b0);
            n++;
        end
        check_val("drain_scoreboard", 64'(sb.size()), 64'd0);
        check_val("drain_fifo", 64'(fifo_q.size()), 64'd0);
    endtask

    task automatic check_outs_zero(input string tag);
        check_val({tag, "_valid"}, 64'(out_Valid), 64'd0);
        check_val({tag, "_data"},  64'(out_Data),  64'd0);
        check_val({tag, "_keep"},  64'(out_Keep),  64'd0);
        check_val({tag, "_last"},  64'(out_Last),  64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        r_Rst = 1'b1; fifo_Empty = 1'b1; read_Data = '0; flush_Req = 1'b0; out_Ready = 1'b1;

        // Reset state
        repeat (3) step(1'b0);
        @(posedge r_Clk); #1;
        check_outs_zero("reset");
        rst_q = 0;

        // Full beats, ready held high, latency and spacing
        beat_cyc.delete(); first_pop_cyc = -1;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        drain(100);
        check_val("t1_beat_count", 64'(beat_cyc.size()), 64'd2);
        if (beat_cyc.size() >= 2) begin
            check_val("t1_first_latency", 64'(beat_cyc[0] - first_pop_cyc), 64'd5);
            check_val("t1_beat_spacing", 64'(beat_cyc[1] - beat_cyc[0]), 64'd4);
        end

        // Backpressure: pops stall with one beat held and one accumulated
        pops = 0; rdy_mode = 0;
        for (int i = 1; i <= 12; i++) fifo_q.push_back(8'(i));
        repeat (10) step(1'b0);
        check_val("t2_hold_data_a", 64'(out_Data), 64'h04030201);
        repeat (10) step(1'b0);
        check_val("t2_pops", 64'(pops), 64'd8);
        check_val("t2_hold_valid", 64'(out_Valid), 64'd1);
        check_val("t2_hold_data_b", 64'(out_Data), 64'h04030201);
        check_val("t2_hold_keep", 64'(out_Keep), 64'hF);
        rdy_mode = 1;
        drain(100);

        // Flush of partial beats; no pop while flush is pending
        fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB);
        drain(20);
        step(1'b1);
        fifo_q.push_back(8'hCC);
        chk_noinc = 1;
        step(1'b0);
        chk_noinc = 0;
        step(1'b0);
        step(1'b1);
        drain(20);

        // Flush with empty accumulator and empty FIFO is ignored
        step(1'b1);
        repeat (4) step(1'b0);
        check_val("t4_idle_valid", 64'(out_Valid), 64'd0);
        check_val("t4_idle_inc", 64'(r_Inc), 64'd0);
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h21 + i));
        drain(50);

        // Reset mid-beat with a held beat and three accumulated words
        rdy_mode = 0;
        for (int i = 1; i <= 7; i++) fifo_q.push_back(8'(i));
        repeat (10) step(1'b0);
        check_val("t5_pre_valid", 64'(out_Valid), 64'd1);
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'hEE);
        rst_q = 1;
        step(1'b0);
        @(posedge r_Clk); #1;
        check_outs_zero("t5_reset");
        fifo_q.delete(); sb.delete(); part.delete();
        rst_q = 0; rdy_mode = 1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h11 + i));
        drain(50);

        // Random FIFO availability and random backpressure
        gate_rand = 1; rdy_mode = 2;
        for (int i = 0; i < 200; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
        drain(3000);
        gate_rand = 0; rdy_mode = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL have parameter data_Size, default 8, meaning the FIFO word width in bits.
REQ-002 The block SHALL have parameter pack_Count, default 4, range 2..8, meaning the number of FIFO words packed per output beat.
REQ-003 The block SHALL have input r_Clk, 1 bit: the single clock, the read-side clock of the async FIFO; all state changes on its rising edge.
REQ-004 The block SHALL have input r_Rst, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input fifo_Empty, 1 bit: FIFO empty flag.
REQ-006 The block SHALL have input read_Data, data_Size bits: FIFO head word, valid whenever fifo_Empty=0.
REQ-007 The block SHALL have output r_Inc, 1 bit: FIFO pop strobe; the head word is consumed on each r_Clk edge where r_Inc=1.
REQ-008 The block SHALL have input flush_Req, 1 bit: single-cycle request to emit a partially filled beat.
REQ-009 The block SHALL have output out_Data, data_Size*pack_Count bits: packed beat.
REQ-010 The block SHALL have output out_Keep, pack_Count bits: per-lane valid mask.
REQ-011 The block SHALL have output out_Last, 1 bit: marks a flushed beat.
REQ-012 The block SHALL have output out_Valid, 1 bit, and input out_Ready, 1 bit: downstream handshake; a beat transfers on an edge with both high.

Function
REQ-013 The accumulator SHALL hold up to pack_Count words plus a count acc_Cnt (0..pack_Count).
REQ-014 The first word popped into an empty accumulator SHALL occupy lane 0 (out_Data[data_Size-1:0]); later words SHALL fill ascending lanes.
REQ-015 The output register SHALL be "free" when out_Valid=0 or out_Ready=1.
REQ-016 A move SHALL occur when (acc_Cnt=pack_Count, or flush_Pend=1 with acc_Cnt>0) and the output register is free; the move loads out_Data, sets out_Keep to acc_Cnt ones from lane 0 and unused lanes zero, sets out_Last=flush_Pend, sets out_Valid=1, clears acc_Cnt.
REQ-017 r_Inc SHALL be combinational: fifo_Empty=0 AND flush_Pend=0 AND (acc_Cnt<pack_Count OR move this cycle).
REQ-018 A pop coinciding with a move SHALL land in lane 0 with acc_Cnt=1 afterwards, so sustained throughput is one beat per pack_Count cycles.
REQ-019 out_Valid SHALL rise on the edge after the pop that completes the accumulator, given a free output register.
REQ-020 When out_Valid=1 and out_Ready=0, out_Data, out_Keep and out_Last SHALL hold stable; pops SHALL stall once acc_Cnt=pack_Count.
REQ-021 out_Valid SHALL clear on a handshake edge with no simultaneous move.
REQ-022 flush_Req with acc_Cnt>0 (after that cycle's pop) SHALL set flush_Pend; flush_Pend SHALL clear on the move it causes.
REQ-023 flush_Req with accumulator empty and no pop that cycle SHALL be ignored.
REQ-024 flush_Req while flush_Pend=1 SHALL be ignored.
REQ-025 A full accumulator SHALL take priority: a flush then moves it as a full beat with out_Last=1.
REQ-026 fifo_Empty=1 SHALL never produce r_Inc=1, regardless of other state.

Reset
REQ-027 While r_Rst=1, r_Inc SHALL be 0 combinationally.
REQ-028 On an edge with r_Rst=1: out_Valid=0, out_Last=0, out_Keep=0, out_Data=0, acc_Cnt=0, flush_Pend=0; reset mid-beat discards accumulated and held words.
REQ-029 The first pop SHALL occur no earlier than the first edge after r_Rst deasserts.

Structure
REQ-030 A shared package SHALL hold pack_Count bounds, the acc_Cnt width function ($clog2(pack_Count+1)) and the keep-mask generation function.
REQ-031 The output register SHALL be one sub-module, rd_out_stage (valid/ready holding register); accumulator, flush logic and pop logic SHALL live in fifo_rd_packer.

Verification
REQ-032 Reset, then FIFO preloaded with 01..08, out_Ready=1 -> beats 0x04030201 and 0x08070605, out_Keep=0xF, out_Last=0, beats 5 cycles after first pop and 4 cycles apart.
REQ-033 Preload 01..0C, out_Ready=0 for 20 cycles, then 1 -> r_Inc stops after 8 pops; held beat 0x04030201 stays stable; all three beats then emerge in order.
REQ-034 Pop AA, BB, then flush_Req -> beat 0x0000BBAA, out_Keep=0x3, out_Last=1; no pop during flush_Pend.
REQ-035 flush_Req with empty accumulator and fifo_Empty=1 -> no beat, state unchanged.
REQ-036 r_Rst=1 asserted after 3 pops with out_Valid=1 and out_Ready=0 -> next edge all outputs 0, r_Inc=0 during reset, next beat after release starts at lane 0.
REQ-037 fifo_Empty toggling randomly, out_Ready random, 200 words -> output lane stream equals input order, no r_Inc while fifo_Empty=1.
